parqueo_ctrl: RTL and testbench

//  Sequential, parametrised parking-lot controller for N_SPOTS spaces.
//  - Debounces the raw spot sensors.
//  - Maintains a registered free-space count and the allfree/full flags.
//  - Drives an entry-gate state machine with a request/pass handshake.
//  - Sits between the spot sensor inputs and the entry barrier/display logic.

---
 rtl/parqueo_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_parqueo_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/parqueo_ctrl.sv
// -----------------------------------------------------------------------------
// parqueo_ctrl
//
// Purpose:
//   Parking-lot controller for N_SPOTS spaces. It debounces the raw spot
//   sensors, keeps a registered count of free spots with allfree/full flags,
//   and runs the entry-gate state machine with a request/pass handshake.
//
// Parameters:
//   N_SPOTS    number of spots/sensors (>=2)
//   DB_CYCLES  consecutive stable cycles needed to accept a sensor change (>=1)
//   GATE_TO    cycles the gate stays open waiting for car_pass (>=2)
//   CW         width of free_cnt, $clog2(N_SPOTS+1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   p          raw sensors, 1 = spot occupied, bit i = spot i
//   car_req    car waiting at entry (level)
//   car_pass   car crossing gate beam (level)
//   free_cnt   debounced number of free spots
//   allfree    free_cnt == N_SPOTS
//   full       free_cnt == 0
//   gate_open  barrier open command
//   grant      1-cycle pulse, entry accepted
//   deny       1-cycle pulse, entry refused because the lot is full
//   pair_free  two adjacent spots free (only with PARQUEO_PAIR_EN, else 0)
//
// Configuration macro:
//   PARQUEO_PAIR_EN  enables the adjacent-free-pair detector on pair_free.
// -----------------------------------------------------------------------------
module parqueo_ctrl #(
  parameter int N_SPOTS   = 4,
  parameter int DB_CYCLES = 8,
  parameter int GATE_TO   = 64,
  localparam int CW       = $clog2(N_SPOTS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SPOTS-1:0] p,
  input  logic               car_req,
  input  logic               car_pass,
  output logic [CW-1:0]      free_cnt,
  output logic               allfree,
  output logic               full,
  output logic               gate_open,
  output logic               grant,
  output logic               deny,
  output logic               pair_free
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TW  = (GATE_TO > 1) ? $clog2(GATE_TO) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  TO_LOAD = TW'(GATE_TO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    PASS = 2'd2
  } gate_state_t;

  logic [N_SPOTS-1:0] s;
  logic [DBW-1:0]     db_cnt [N_SPOTS];
  logic [CW-1:0]      free_next;
  gate_state_t        state;
  logic [TW-1:0]      timer;
  logic               deny_lock;

  // Per-spot debounce: a sensor that disagrees with its accepted state must
  // keep disagreeing for DB_CYCLES consecutive edges before the accepted
  // state follows it. Any agreeing cycle restarts the count, so short
  // glitches never reach s.
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      for (int i = 0; i < N_SPOTS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SPOTS; i++) begin
        if (p[i] != s[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            s[i]      <= p[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Number of free spots in the debounced state (popcount of ~s).
  always_comb begin
    free_next = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      free_next = free_next + CW'(!s[i]);
    end
  end

  // Count and flags are registered from the same value, so allfree and full
  // always agree with the free_cnt shown on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_cnt <= CW'(N_SPOTS);
      allfree  <= 1'b1;
      full     <= 1'b0;
    end else begin
      free_cnt <= free_next;
      allfree  <= (free_next == CW'(N_SPOTS));
      full     <= (free_next == '0);
    end
  end

`ifdef PARQUEO_PAIR_EN
  logic pair_next;

  // Adjacent free pair detector; spot 0 and the last spot are not
  // neighbours, so there is no wrap-around term.
  always_comb begin
    pair_next = 1'b0;
    for (int i = 0; i < N_SPOTS - 1; i++) begin
      pair_next = pair_next | (!s[i] & !s[i+1]);
    end
  end

  // Registered alongside free_cnt so both views of the lot update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_free <= 1'b0;
    end else begin
      pair_free <= pair_next;
    end
  end
`else
  assign pair_free = 1'b0;
`endif

  // Entry gate FSM. grant/deny default low so they are single-cycle pulses.
  // deny_lock makes refusals edge-qualified: once a waiting car is denied it
  // is not denied again until car_req has dropped for at least one cycle.
  // full is the registered flag, i.e. the lot state on the cycle the request
  // is taken. In OPEN, car_pass is tested before the timeout so a car arriving
  // on the final cycle still gets through.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gate_open <= 1'b0;
      grant     <= 1'b0;
      deny      <= 1'b0;
      timer     <= '0;
      deny_lock <= 1'b0;
    end else begin
      grant <= 1'b0;
      deny  <= 1'b0;
      if (!car_req) begin
        deny_lock <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (car_req) begin
            if (full) begin
              if (!deny_lock) begin
                deny      <= 1'b1;
                deny_lock <= 1'b1;
              end
            end else begin
              grant     <= 1'b1;
              gate_open <= 1'b1;
              timer     <= TO_LOAD;
              state     <= OPEN;
            end
          end
        end
        OPEN: begin
          if (car_pass) begin
            state <= PASS;
          end else if (timer == '0) begin
            gate_open <= 1'b0;
            state     <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        PASS: begin
          if (!car_pass) begin
            gate_open <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          gate_open <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parqueo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parqueo_ctrl
//
// Purpose:
//   Directed self-checking bench for parqueo_ctrl with N_SPOTS=4,
//   DB_CYCLES=8, GATE_TO=64. Inputs change 1 time unit after a rising edge
//   and outputs are sampled at that same point, so each sample shows the
//   registers as updated by the preceding edge.
//
// Configuration macro:
//   PARQUEO_PAIR_EN  when defined, pair_free expectations follow adjacency.
// -----------------------------------------------------------------------------
module tb_parqueo_ctrl;

  localparam int N_SPOTS   = 4;
  localparam int DB_CYCLES = 8;
  localparam int GATE_TO   = 64;
  localparam int CW        = $clog2(N_SPOTS + 1);

`ifdef PARQUEO_PAIR_EN
  localparam logic PAIR_EN = 1'b1;
`else
  localparam logic PAIR_EN = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [N_SPOTS-1:0] p;
  logic               car_req;
  logic               car_pass;
  logic [CW-1:0]      free_cnt;
  logic               allfree;
  logic               full;
  logic               gate_open;
  logic               grant;
  logic               deny;
  logic               pair_free;

  int n_compared   = 0;
  int n_mismatched = 0;

  parqueo_ctrl #(
    .N_SPOTS  (N_SPOTS),
    .DB_CYCLES(DB_CYCLES),
    .GATE_TO  (GATE_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .p        (p),
    .car_req  (car_req),
    .car_pass (car_pass),
    .free_cnt (free_cnt),
    .allfree  (allfree),
    .full     (full),
    .gate_open(gate_open),
    .grant    (grant),
    .deny     (deny),
    .pair_free(pair_free)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, landing 1 unit after the last one.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive every DUT input at once.
  task automatic applyStimulus(input logic [N_SPOTS-1:0] p_v, input logic req_v,
                               input logic pass_v, input logic rst_v);
    p        = p_v;
    car_req  = req_v;
    car_pass = pass_v;
    rst      = rst_v;
  endtask

  // One comparison: counts it, and on a miss counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    int deny_seen;
    int grant_seen;

    // 1. Reset with all spots empty.
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("rst_free_cnt", 32'(free_cnt), 32'd4);
    checkOutput("rst_allfree", 32'(allfree), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_gate_open", 32'(gate_open), 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_deny", 32'(deny), 32'd0);
    checkOutput("rst_pair_free", 32'(pair_free), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    step(1);

    // 2. Occupy spots 0 and 2; s follows on edge 8, free_cnt on edge 9.
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    step(8);
    checkOutput("db_edge8_free_cnt", 32'(free_cnt), 32'd4);
    step(1);
    checkOutput("db_edge9_free_cnt", 32'(free_cnt), 32'd2);
    checkOutput("db_edge9_allfree", 32'(allfree), 32'd0);
    checkOutput("db_edge9_full", 32'(full), 32'd0);
    // 5-cycle glitch on spot 1 must be rejected.
    applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0);
    step(5);
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    step(10);
    checkOutput("glitch_free_cnt", 32'(free_cnt), 32'd2);

    // 3. Lot full: one deny pulse, none repeated while car_req stays high.
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    step(9);
    checkOutput("full_free_cnt", 32'(free_cnt), 32'd0);
    checkOutput("full_flag", 32'(full), 32'd1);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("deny_pulse", 32'(deny), 32'd1);
    checkOutput("deny_no_grant", 32'(grant), 32'd0);
    checkOutput("deny_gate_closed", 32'(gate_open), 32'd0);
    deny_seen  = 0;
    grant_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (deny) deny_seen++;
      if (grant) grant_seen++;
    end
    checkOutput("no_second_deny", 32'(deny_seen), 32'd0);
    checkOutput("no_grant_when_full", 32'(grant_seen), 32'd0);
    // Dropping car_req re-arms the refusal.
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    step(1);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("deny_rearmed", 32'(deny), 32'd1);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    step(1);

    // 4. Free spot 0, grant, car passes for 3 cycles.
    applyStimulus(4'b1110, 1'b0, 1'b0, 1'b0);
    step(9);
    checkOutput("one_free_cnt", 32'(free_cnt), 32'd1);
    checkOutput("one_free_full", 32'(full), 32'd0);
    applyStimulus(4'b1110, 1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("grant_pulse", 32'(grant), 32'd1);
    checkOutput("grant_no_deny", 32'(deny), 32'd0);
    checkOutput("grant_gate_open", 32'(gate_open), 32'd1);
    applyStimulus(4'b1110, 1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("grant_pulse_end", 32'(grant), 32'd0);
    checkOutput("open_gate_held", 32'(gate_open), 32'd1);
    applyStimulus(4'b1110, 1'b0, 1'b1, 1'b0);
    step(3);
    checkOutput("pass_gate_held", 32'(gate_open), 32'd1);
    applyStimulus(4'b1110, 1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("pass_done_gate", 32'(gate_open), 32'd0);

    // 5a. Timeout: open on the grant edge, closed exactly 64 edges later.
    applyStimulus(4'b1110, 1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("to_grant", 32'(grant), 32'd1);
    applyStimulus(4'b1110, 1'b0, 1'b0, 1'b0);
    step(63);
    checkOutput("to_gate_edge63", 32'(gate_open), 32'd1);
    step(1);
    checkOutput("to_gate_edge64", 32'(gate_open), 32'd0);

    // 5b. car_pass on the timeout cycle wins; gate stays open in PASS.
    applyStimulus(4'b1110, 1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("tp_grant", 32'(grant), 32'd1);
    applyStimulus(4'b1110, 1'b0, 1'b0, 1'b0);
    step(63);
    applyStimulus(4'b1110, 1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("tp_gate_edge64", 32'(gate_open), 32'd1);
    step(3);
    checkOutput("tp_gate_in_pass", 32'(gate_open), 32'd1);

    // 6a. Reset during PASS closes the gate on the next edge.
    applyStimulus(4'b1110, 1'b0, 1'b1, 1'b1);
    step(1);
    checkOutput("rst_pass_gate", 32'(gate_open), 32'd0);
    checkOutput("rst_pass_free_cnt", 32'(free_cnt), 32'd4);
    applyStimulus(4'b1010, 1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("rst_pass_stays_closed", 32'(gate_open), 32'd0);

    // 6b. Adjacency: spots 0,2 free -> no pair.
    applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
    step(9);
    checkOutput("p1010_free_cnt", 32'(free_cnt), 32'd2);
    checkOutput("p1010_pair_free", 32'(pair_free), 32'd0);
    // Spots 1,2 free -> pair.
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
    step(9);
    checkOutput("p1001_free_cnt", 32'(free_cnt), 32'd2);
    checkOutput("p1001_pair_free", 32'(pair_free), 32'(PAIR_EN));
    // Spots 0,3 free -> not adjacent, no wrap.
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0);
    step(9);
    checkOutput("p0110_free_cnt", 32'(free_cnt), 32'd2);
    checkOutput("p0110_pair_free", 32'(pair_free), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
